// File: rtl/tl_pkg.sv
// TileLink-UL shared types: A/D opcode enums, packed beat structs, beat-count helper.
`ifndef TL_PKG_SV
`define TL_PKG_SV

`define TL_DECLARE(DW, AW, SZW, SRCW, SNKW) \
    typedef struct packed {                 \
        tl_a_op_e          opcode;          \
        logic [2:0]        param;           \
        logic [(SZW)-1:0]  size;            \
        logic [(SRCW)-1:0] source;          \
        logic [(AW)-1:0]   address;         \
        logic [(DW)/8-1:0] mask;            \
        logic              corrupt;         \
        logic [(DW)-1:0]   data;            \
    } tl_a_t;                               \
    typedef struct packed {                 \
        tl_d_op_e          opcode;          \
        logic [2:0]        param;           \
        logic [(SZW)-1:0]  size;            \
        logic [(SRCW)-1:0] source;          \
        logic [(SNKW)-1:0] sink;            \
        logic              denied;          \
        logic              corrupt;         \
        logic [(DW)-1:0]   data;            \
    } tl_d_t;

package tl_pkg;

    localparam int unsigned TL_DW   = 64;
    localparam int unsigned TL_AW   = 56;
    localparam int unsigned TL_SZW  = 3;
    localparam int unsigned TL_SRCW = 1;
    localparam int unsigned TL_SNKW = 1;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    `TL_DECLARE(TL_DW, TL_AW, TL_SZW, TL_SRCW, TL_SNKW)

    // Beats in a burst: max(1, 2^size >> off_bits). Sizes beyond eight beats
    // are outside the supported range and are clamped to eight.
    function automatic logic [3:0] beats_of(input logic [TL_SZW-1:0] size,
                                            input int unsigned off_bits);
        int unsigned s;
        s = int'(size);
        if (s <= off_bits) begin
            return 4'd1;
        end else if ((s - off_bits) >= 3) begin
            return 4'd8;
        end else begin
            return 4'(1 << (s - off_bits));
        end
    endfunction

endpackage

`endif

// File: rtl/tl_ram_rsp_fifo.sv
// Two-entry first-word-fall-through buffer of D-channel beats.
module tl_ram_rsp_fifo
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tl_d_t      wdata,
    input  logic       pop,
    output tl_d_t      rdata,
    output logic       valid,
    output logic       full,
    output logic [1:0] count
);

    tl_d_t      mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic       do_push;
    logic       do_pop;

    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage, no reset needed: contents are only observed while valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tl_ram_device.sv
// TileLink-UL device backed by a single-port synchronous SRAM.
// Optional macro TL_RAM_RANGE_CHECK_EN: deny requests beyond DepthWords.
module tl_ram_device
    import tl_pkg::*;
#(
    parameter int unsigned DepthWords = 8192
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tl_a_valid_i,
    output logic                          tl_a_ready_o,
    input  tl_a_t                         tl_a_i,
    output logic                          tl_d_valid_o,
    input  logic                          tl_d_ready_i,
    output tl_d_t                         tl_d_o,
    output logic                          sram_req_o,
    output logic                          sram_we_o,
    output logic [$clog2(DepthWords)-1:0] sram_addr_o,
    output logic [TL_DW/8-1:0]            sram_wmask_o,
    output logic [TL_DW-1:0]              sram_wdata_o,
    input  logic [TL_DW-1:0]              sram_rdata_i
);

    localparam int unsigned OffBits = $clog2(TL_DW / 8);
    localparam int unsigned IW      = $clog2(DepthWords);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          last_q, last_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [TL_SZW-1:0]   size_q, size_d;
    logic [TL_SRCW-1:0]  src_q, src_d;
    logic                err_q, err_d;
    logic                den_q, den_d;
    logic                intent_q, intent_d;
    logic                inflight_q, inflight_d;

    logic                a_ready;
    logic                sram_req;
    logic [IW-1:0]       a_idx;
    logic [IW-1:0]       beat_idx;
    logic [3:0]          a_last;
    logic                range_err;
    logic                push_en;
    tl_d_t               push_beat;
    tl_d_t               fifo_beat;
    logic                fifo_valid;
    logic                fifo_full;
    logic [1:0]          fifo_count;
    logic                unused_a;

    assign a_idx    = tl_a_i.address[OffBits +: IW];
    assign beat_idx = idx_q + IW'(cnt_q);
    assign a_last   = beats_of(tl_a_i.size, OffBits) - 4'd1;
    assign unused_a = ^{tl_a_i.param, tl_a_i.address};

`ifdef TL_RAM_RANGE_CHECK_EN
    assign range_err = (tl_a_i.address >> OffBits) >= TL_AW'(DepthWords);
`else
    assign range_err = 1'b0;
`endif

    assign tl_a_ready_o = a_ready;
    assign sram_req_o   = sram_req && !rst_i;
    assign tl_d_valid_o = fifo_valid && !rst_i;
    assign tl_d_o       = fifo_beat;

    // Registered request context and FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= '0;
            idx_q      <= '0;
            size_q     <= '0;
            src_q      <= '0;
            err_q      <= 1'b0;
            den_q      <= 1'b0;
            intent_q   <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            size_q     <= size_d;
            src_q      <= src_d;
            err_q      <= err_d;
            den_q      <= den_d;
            intent_q   <= intent_d;
            inflight_q <= inflight_d;
        end
    end

    // Next-state, SRAM strobes and response generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        idx_d      = idx_q;
        size_d     = size_q;
        src_d      = src_q;
        err_d      = err_q;
        den_d      = den_q;
        intent_d   = intent_q;
        inflight_d = 1'b0;

        a_ready      = 1'b0;
        sram_req     = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = beat_idx;
        sram_wmask_o = '0;
        sram_wdata_o = '0;

        push_en          = 1'b0;
        push_beat        = '0;
        push_beat.opcode = AccessAck;
        push_beat.size   = size_q;
        push_beat.source = src_q;

        // A read issued last cycle returns now; error reads carry no data.
        if (inflight_q) begin
            push_en           = 1'b1;
            push_beat.opcode  = AccessAckData;
            push_beat.denied  = err_q;
            push_beat.corrupt = err_q;
            push_beat.data    = err_q ? '0 : sram_rdata_i;
        end

        case (state_q)
            IDLE: begin
                a_ready = !rst_i && !inflight_q && !fifo_full;
                if (tl_a_valid_i && a_ready) begin
                    size_d   = tl_a_i.size;
                    src_d    = tl_a_i.source;
                    idx_d    = a_idx;
                    last_d   = a_last;
                    cnt_d    = 4'd1;
                    err_d    = range_err;
                    den_d    = tl_a_i.corrupt || range_err;
                    intent_d = 1'b0;
                    push_beat.size   = tl_a_i.size;
                    push_beat.source = tl_a_i.source;
                    case (tl_a_i.opcode)
                        Get: begin
                            cnt_d   = 4'd0;
                            state_d = READ;
                        end
                        PutFullData, PutPartialData: begin
                            if (!tl_a_i.corrupt && !range_err) begin
                                sram_req     = 1'b1;
                                sram_we_o    = 1'b1;
                                sram_addr_o  = a_idx;
                                sram_wmask_o = tl_a_i.mask;
                                sram_wdata_o = tl_a_i.data;
                            end
                            if (a_last == 4'd0) begin
                                push_en          = 1'b1;
                                push_beat.denied = tl_a_i.corrupt || range_err;
                            end else begin
                                state_d = WRITE;
                            end
                        end
                        ArithmeticData, LogicalData: begin
                            push_en           = 1'b1;
                            push_beat.opcode  = AccessAckData;
                            push_beat.denied  = 1'b1;
                            push_beat.corrupt = 1'b1;
                            if (a_last != 4'd0) state_d = DRAIN;
                        end
                        default: begin
                            intent_d = 1'b1;
                            if (a_last == 4'd0) begin
                                push_en          = 1'b1;
                                push_beat.denied = 1'b1;
                            end else begin
                                state_d = DRAIN;
                            end
                        end
                    endcase
                end
            end

            READ: begin
                // Never let buffered plus in-flight beats exceed the FIFO.
                if (({1'b0, fifo_count} + {2'b00, inflight_q}) < 3'd2) begin
                    sram_req   = !err_q;
                    inflight_d = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == last_q) state_d = IDLE;
                end
            end

            WRITE: begin
                a_ready = !rst_i && ((cnt_q != last_q) || !fifo_full);
                if (tl_a_valid_i && a_ready) begin
                    if (!tl_a_i.corrupt && !err_q) begin
                        sram_req     = 1'b1;
                        sram_we_o    = 1'b1;
                        sram_wmask_o = tl_a_i.mask;
                        sram_wdata_o = tl_a_i.data;
                    end
                    den_d = den_q || tl_a_i.corrupt;
                    if (cnt_q == last_q) begin
                        push_en          = 1'b1;
                        push_beat.denied = den_q || tl_a_i.corrupt;
                        state_d          = IDLE;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            DRAIN: begin
                a_ready = !rst_i && ((intent_q && (cnt_q != last_q)) || !fifo_full);
                if (tl_a_valid_i && a_ready) begin
                    if (!intent_q) begin
                        push_en           = 1'b1;
                        push_beat.opcode  = AccessAckData;
                        push_beat.denied  = 1'b1;
                        push_beat.corrupt = 1'b1;
                    end else if (cnt_q == last_q) begin
                        push_en          = 1'b1;
                        push_beat.denied = 1'b1;
                    end
                    if (cnt_q == last_q) state_d = IDLE;
                    else                 cnt_d   = cnt_q + 4'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    tl_ram_rsp_fifo u_rsp_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push_en),
        .wdata (push_beat),
        .pop   (tl_d_valid_o && tl_d_ready_i),
        .rdata (fifo_beat),
        .valid (fifo_valid),
        .full  (fifo_full),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_tl_ram_device.sv
// Directed scoreboard bench for tl_ram_device.
module tb_tl_ram_device;
    import tl_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid;
    logic              a_ready;
    tl_a_t             a;
    logic              d_valid;
    logic              d_ready;
    tl_d_t             d;
    logic              sram_req;
    logic              sram_we;
    logic [12:0]       sram_addr;
    logic [7:0]        sram_wmask;
    logic [63:0]       sram_wdata;
    logic [63:0]       sram_rdata;

    logic [63:0]       mem [8192];
    tl_d_t             exp_q [$];
    int unsigned       checks = 0;
    int unsigned       errors = 0;
    int unsigned       req_cnt = 0;
    int unsigned       rd_cnt = 0;

    always #5 clk = ~clk;

    tl_ram_device #(.DepthWords(8192)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tl_a_valid_i (a_valid),
        .tl_a_ready_o (a_ready),
        .tl_a_i       (a),
        .tl_d_valid_o (d_valid),
        .tl_d_ready_i (d_ready),
        .tl_d_o       (d),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wmask_o (sram_wmask),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    // SRAM model: byte-masked write, read data one cycle after req.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] = sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] hdr(input tl_d_t x);
        return 64'({x.opcode, x.param, x.size, x.source, x.sink, x.denied, x.corrupt});
    endfunction

    function automatic tl_d_t mk(input tl_d_op_e op, input logic [2:0] sz, input logic src,
                                 input logic den, input logic cor, input logic [63:0] dat);
        tl_d_t r;
        r = '0;
        r.opcode  = op;
        r.size    = sz;
        r.source  = src;
        r.denied  = den;
        r.corrupt = cor;
        r.data    = dat;
        return r;
    endfunction

    // D-channel monitor: every accepted beat is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && d_valid && d_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_d: observed beat data %h, expected no response", d.data);
            end
            if (exp_q.size() != 0) begin
                tl_d_t e;
                e = exp_q.pop_front();
                chk("d_hdr", hdr(d), hdr(e));
                chk("d_data", d.data, e.data);
            end
        end
        if (sram_req) begin
            req_cnt++;
            if (!sram_we) rd_cnt++;
        end
    end

    // Drive one A beat (caller sits just after a posedge) and wait for its handshake.
    task automatic send_a(input tl_a_op_e op, input logic [2:0] size, input logic src,
                          input logic [55:0] addr, input logic [7:0] mask,
                          input logic [63:0] data, input logic cor);
        int unsigned n;
        n = 0;
        a_valid   = 1'b1;
        a.opcode  = op;
        a.param   = '0;
        a.size    = size;
        a.source  = src;
        a.address = addr;
        a.mask    = mask;
        a.corrupt = cor;
        a.data    = data;
        do begin
            @(negedge clk);
            n++;
        end while (!a_ready && n < 200);
        chk("a_handshake", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned n;
        int unsigned r0;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        rst     = 1'b1;
        a_valid = 1'b0;
        a       = '0;
        d_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a_ready", 64'(a_ready), 64'd0);
        chk("rst_d_valid", 64'(d_valid), 64'd0);
        chk("rst_sram_req", 64'(sram_req), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_a_ready", 64'(a_ready), 64'd1);
        chk("idle_d_valid", 64'(d_valid), 64'd0);
        @(posedge clk);
        #1;

        // Single-beat Get and its latency.
        mem[8] = 64'hDEAD_BEEF_0123_4567;
        exp_q.push_back(mk(AccessAckData, 3'd3, 1'b1, 1'b0, 1'b0, 64'hDEAD_BEEF_0123_4567));
        send_a(Get, 3'd3, 1'b1, 56'h40, 8'hFF, '0, 1'b0);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (d_valid) break;
            n++;
        end
        chk("get_latency", 64'(n), 64'd2);
        wait_drain();

        // 8-beat PutFull then 8-beat Get.
        exp_q.push_back(mk(AccessAck, 3'd6, 1'b0, 1'b0, 1'b0, '0));
        for (int i = 0; i < 8; i++)
            send_a(PutFullData, 3'd6, 1'b0, 56'h100, 8'hFF, 64'(i), 1'b0);
        @(negedge clk);
        chk("put_ack_timing", 64'(d_valid), 64'd1);
        @(posedge clk);
        #1;
        wait_drain();
        for (int i = 0; i < 8; i++)
            exp_q.push_back(mk(AccessAckData, 3'd6, 1'b0, 1'b0, 1'b0, 64'(i)));
        send_a(Get, 3'd6, 1'b0, 56'h100, 8'hFF, '0, 1'b0);
        wait_drain();

        // PutPartial lower four bytes.
        exp_q.push_back(mk(AccessAck, 3'd3, 1'b0, 1'b0, 1'b0, '0));
        send_a(PutPartialData, 3'd3, 1'b0, 56'h0, 8'h0F, '1, 1'b0);
        wait_drain();
        exp_q.push_back(mk(AccessAckData, 3'd3, 1'b0, 1'b0, 1'b0, 64'h0000_0000_FFFF_FFFF));
        send_a(Get, 3'd3, 1'b0, 56'h0, 8'hFF, '0, 1'b0);
        wait_drain();

        // Get under D backpressure.
        d_ready = 1'b0;
        r0 = rd_cnt;
        for (int i = 0; i < 8; i++)
            exp_q.push_back(mk(AccessAckData, 3'd6, 1'b1, 1'b0, 1'b0, 64'(i)));
        send_a(Get, 3'd6, 1'b1, 56'h100, 8'hFF, '0, 1'b0);
        repeat (10) @(negedge clk);
        chk("bp_reads", 64'(rd_cnt - r0), 64'd2);
        chk("bp_d_valid", 64'(d_valid), 64'd1);
        chk("bp_head_data", d.data, 64'd0);
        @(posedge clk);
        #1;
        d_ready = 1'b1;
        wait_drain();
        chk("bp_total_reads", 64'(rd_cnt - r0), 64'd8);

        // Unsupported Arithmetic: consumed, denied, no SRAM access.
        r0 = req_cnt;
        exp_q.push_back(mk(AccessAckData, 3'd3, 1'b0, 1'b1, 1'b1, '0));
        send_a(ArithmeticData, 3'd3, 1'b0, 56'h40, 8'hFF, 64'h1234, 1'b0);
        wait_drain();
        chk("arith_no_sram", 64'(req_cnt - r0), 64'd0);

        // Intent: single denied AccessAck.
        exp_q.push_back(mk(AccessAck, 3'd3, 1'b1, 1'b1, 1'b0, '0));
        send_a(Intent, 3'd3, 1'b1, 56'h40, 8'hFF, '0, 1'b0);
        wait_drain();

        // Corrupt second beat: write suppressed, ack denied.
        exp_q.push_back(mk(AccessAck, 3'd4, 1'b0, 1'b1, 1'b0, '0));
        send_a(PutFullData, 3'd4, 1'b0, 56'h300, 8'hFF, 64'h1111, 1'b0);
        send_a(PutFullData, 3'd4, 1'b0, 56'h300, 8'hFF, 64'h2222, 1'b1);
        wait_drain();
        exp_q.push_back(mk(AccessAckData, 3'd4, 1'b0, 1'b0, 1'b0, 64'h1111));
        exp_q.push_back(mk(AccessAckData, 3'd4, 1'b0, 1'b0, 1'b0, 64'h0));
        send_a(Get, 3'd4, 1'b0, 56'h300, 8'hFF, '0, 1'b0);
        wait_drain();

        // Reset in the middle of an 8-beat Put.
        for (int i = 0; i < 4; i++)
            send_a(PutFullData, 3'd6, 1'b0, 56'h200, 8'hFF, 64'hA0 + 64'(i), 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_a_ready", 64'(a_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_d_valid", 64'(d_valid), 64'd0);
        chk("post_rst_a_ready", 64'(a_ready), 64'd1);
        @(posedge clk);
        #1;
        exp_q.push_back(mk(AccessAckData, 3'd3, 1'b0, 1'b0, 1'b0, 64'hA3));
        send_a(Get, 3'd3, 1'b0, 56'h218, 8'hFF, '0, 1'b0);
        wait_drain();
        exp_q.push_back(mk(AccessAckData, 3'd3, 1'b0, 1'b0, 1'b0, 64'h0));
        send_a(Get, 3'd3, 1'b0, 56'h220, 8'hFF, '0, 1'b0);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
